mux_lut_logic_unit: RTL and testbench

- Parametrised successor to the fixed 2:1-mux gate set; W-lane, K-input logic unit.
- Each lane's result is one bit of a 2^K-entry truth table, selected by a balanced tree of 2:1 muxes indexed by the lane's K operand bits.
- Supports preset gate functions and a runtime-loadable custom table.
- Two-stage valid/ready pipeline; sits between operand producers and downstream logic consumers.

---
 rtl/mux_lut_logic_unit.sv | 142 ++++++++++++++
 tb/tb_mux_lut_logic_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_lut_logic_unit.sv
// W-lane, K-input LUT logic unit: each lane returns one bit of a 2^K-entry truth table via a 2:1 mux tree.
// Latency: beat accepted at edge n is registered on out_data after edge n+1 and consumed at edge n+2 at the earliest.
// Backpressure: two-entry valid/ready pipeline; in_ready combinationally follows out_ready when both stages are full.
module mux_lut_logic_unit #(
    parameter int K = 2,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [K*W-1:0]       in_data,
    input  logic [2:0]           in_op,
    input  logic                 cfg_we,
    input  logic [(1<<K)-1:0]    cfg_table,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic [2:0]           out_op
);

    localparam int N = 1 << K;

    // Runtime-loadable custom table
    logic [N-1:0]   r_custom;

    // Stage 1: operands, op and the truth table resolved at acceptance
    logic           r_s1_valid;
    logic [K*W-1:0] r_s1_data;
    logic [2:0]     r_s1_op;
    logic [N-1:0]   r_s1_tbl;

    // Stage 2: registered result
    logic           r_s2_valid;
    logic [W-1:0]   r_s2_data;
    logic [2:0]     r_s2_op;

    logic           w_s1_load;
    logic           w_s2_load;
    logic [N-1:0]   w_tbl;
    logic [W-1:0]   w_eval;
    logic [2*N-1:1] w_node;

    // Map an op code to its effective truth table; bit idx is the output for operand index idx.
    function automatic logic [N-1:0] f_resolve(input logic [2:0] op, input logic [N-1:0] custom);
        logic [N-1:0] t;
        logic [K-1:0] v;
        t = '0;
        for (int idx = 0; idx < N; idx++) begin
            v = K'(idx);
            case (op)
                3'd0:    t[idx] = ~v[0];
                3'd1:    t[idx] = &v;
                3'd2:    t[idx] = |v;
                3'd3:    t[idx] = ~(&v);
                3'd4:    t[idx] = ~(|v);
                3'd5:    t[idx] = ^v;
                3'd6:    t[idx] = ~(^v);
                default: t[idx] = custom[idx];
            endcase
        end
        return t;
    endfunction

    // Leaves are stored bit-reversed so that operand 0 ends up on the root select.
    function automatic int f_bitrev(input int p);
        int r;
        r = 0;
        for (int b = 0; b < K; b++) begin
            if (p[b]) r = r | (1 << (K - 1 - b));
        end
        return r;
    endfunction

    assign w_s2_load = r_s1_valid & (~r_s2_valid | out_ready);
    assign in_ready  = ~rst & (~r_s1_valid | w_s2_load);
    assign w_s1_load = in_valid & in_ready;
    assign w_tbl     = f_resolve(in_op, r_custom);

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign out_op    = r_s2_op;

    // Per-lane heap-ordered mux tree: node n at depth d is steered by operand d of that lane.
    always_comb begin
        w_eval = '0;
        w_node = '0;
        for (int i = 0; i < W; i++) begin
            for (int p = 0; p < N; p++) begin
                w_node[N + p] = r_s1_tbl[f_bitrev(p)];
            end
            for (int d = K - 1; d >= 0; d--) begin
                for (int n = (1 << d); n < (2 << d); n++) begin
                    w_node[n] = r_s1_data[d*W + i] ? w_node[2*n + 1] : w_node[2*n];
                end
            end
            w_eval[i] = w_node[1];
        end
    end

    // Custom table register; writes land at the edge and affect only later acceptances.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_custom <= '0;
        end else if (cfg_we) begin
            r_custom <= cfg_table;
        end
    end

    // Stage 1 capture with the table resolved against the pre-write custom contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_op    <= '0;
            r_s1_tbl   <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= 1'b1;
            r_s1_data  <= in_data;
            r_s1_op    <= in_op;
            r_s1_tbl   <= w_tbl;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2 result register; data and op hold when not reloaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_op    <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            r_s2_data  <= w_eval;
            r_s2_op    <= r_s1_op;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_lut_logic_unit.sv
// Bench for mux_lut_logic_unit: directed gate checks on a K=2 build plus random streaming on K=2 and K=3 builds.
// Inputs are driven at the falling edge; outputs and in_ready are sampled 1ns later.
// Results are predicted from the gate definitions with plain integer arithmetic and queued in order.
module tb_mux_lut_logic_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // K=2 instance
    logic        in_valid2, in_ready2, cfg_we2, out_valid2, out_ready2;
    logic [15:0] in_data2;
    logic [2:0]  in_op2, out_op2;
    logic [3:0]  cfg_table2;
    logic [7:0]  out_data2;

    // K=3 instance
    logic        in_valid3, in_ready3, cfg_we3, out_valid3, out_ready3;
    logic [23:0] in_data3;
    logic [2:0]  in_op3, out_op3;
    logic [7:0]  cfg_table3;
    logic [7:0]  out_data3;

    mux_lut_logic_unit #(.K(2), .W(8)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_op(in_op2),
        .cfg_we(cfg_we2), .cfg_table(cfg_table2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_op(out_op2)
    );

    mux_lut_logic_unit #(.K(3), .W(8)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3), .in_op(in_op3),
        .cfg_we(cfg_we3), .cfg_table(cfg_table3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3), .out_op(out_op3)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Lane result from the gate definitions: build each lane's operand index and apply the named function.
    function automatic logic [7:0] ref_eval(input int k, input logic [2:0] op,
                                            input logic [31:0] d, input logic [15:0] tbl);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            int idx;
            int ones;
            idx = 0;
            for (int j = 0; j < k; j++) idx += int'(d[j*8 + i]) << j;
            ones = $countones(idx);
            case (op)
                3'd0:    r[i] = (idx % 2) == 0;
                3'd1:    r[i] = idx == (1 << k) - 1;
                3'd2:    r[i] = idx != 0;
                3'd3:    r[i] = idx != (1 << k) - 1;
                3'd4:    r[i] = idx == 0;
                3'd5:    r[i] = (ones % 2) == 1;
                3'd6:    r[i] = (ones % 2) == 0;
                default: r[i] = tbl[idx];
            endcase
        end
        return r;
    endfunction

    task automatic drive2(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                          input logic ordy, input logic we, input logic [3:0] tbl);
        @(negedge clk);
        in_valid2 = v; in_data2 = {b, a}; in_op2 = op;
        out_ready2 = ordy; cfg_we2 = we; cfg_table2 = tbl;
        #1;
    endtask

    // Accept one beat, then confirm it is absent one cycle on and present (with its op) the cycle after.
    task automatic single(input string tag, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp);
        drive2(1'b1, a, b, op, 1'b1, 1'b0, 4'h0);
        chk({tag, "_rdy"}, in_ready2, 1);
        drive2(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 4'h0);
        chk({tag, "_early"}, out_valid2, 0);
        drive2(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 4'h0);
        chk({tag, "_vld"}, out_valid2, 1);
        chk({tag, "_dat"}, out_data2, exp);
        chk({tag, "_op"}, out_op2, op);
        drive2(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 4'h0);
        chk({tag, "_drop"}, out_valid2, 0);
    endtask

    logic [10:0] q2[$];
    logic [10:0] q3[$];
    logic [15:0] m_cust2, m_cust3;
    int n_in2, n_out2, n_in3, n_out3;

    initial begin
        rst = 1'b1;
        in_valid2 = 0; in_data2 = '0; in_op2 = '0; out_ready2 = 0; cfg_we2 = 0; cfg_table2 = '0;
        in_valid3 = 0; in_data3 = '0; in_op3 = '0; out_ready3 = 0; cfg_we3 = 0; cfg_table3 = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready2, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid2, 0);
        chk("rst_out_data", out_data2, 0);
        chk("rst_out_op", out_op2, 0);
        chk("rst_in_ready_rel", in_ready2, 1);

        // Custom table write coinciding with an op-7 acceptance: that beat sees the old (zero) table.
        drive2(1'b1, 8'hF0, 8'hCC, 3'd7, 1'b1, 1'b1, 4'b0010);
        chk("cfg_acc", in_ready2, 1);
        drive2(1'b1, 8'hF0, 8'hCC, 3'd7, 1'b1, 1'b0, 4'h0);
        chk("cfg_acc2", in_ready2, 1);
        drive2(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 4'h0);
        chk("cfg_old_dat", out_data2, 8'h00);
        chk("cfg_old_vld", out_valid2, 1);
        drive2(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 4'h0);
        chk("cfg_new_dat", out_data2, 8'h30);
        chk("cfg_new_op", out_op2, 3'd7);

        single("and",  3'd1, 8'hF0, 8'hCC, 8'hC0);
        single("or",   3'd2, 8'hF0, 8'hCC, 8'hFC);
        single("xor",  3'd5, 8'hF0, 8'hCC, 8'h3C);
        single("xnor", 3'd6, 8'hF0, 8'hCC, 8'hC3);
        single("not",  3'd0, 8'hF0, 8'hAA, 8'h0F);
        single("not2", 3'd0, 8'hF0, 8'h55, 8'h0F);
        single("nand", 3'd3, 8'hF0, 8'hAA, 8'h5F);
        single("nor",  3'd4, 8'hF0, 8'hAA, 8'h05);

        // Backpressure: two beats fit, the third waits until the output drains.
        drive2(1'b1, 8'h01, 8'hFF, 3'd1, 1'b0, 1'b0, 4'h0);
        chk("bp_acc1", in_ready2, 1);
        drive2(1'b1, 8'h02, 8'hFF, 3'd1, 1'b0, 1'b0, 4'h0);
        chk("bp_acc2", in_ready2, 1);
        drive2(1'b1, 8'h03, 8'hFF, 3'd1, 1'b0, 1'b0, 4'h0);
        chk("bp_full", in_ready2, 0);
        chk("bp_hold_a", out_data2, 8'h01);
        drive2(1'b1, 8'h03, 8'hFF, 3'd1, 1'b0, 1'b0, 4'h0);
        chk("bp_full2", in_ready2, 0);
        chk("bp_hold_b", out_data2, 8'h01);
        chk("bp_hold_vld", out_valid2, 1);
        drive2(1'b1, 8'h03, 8'hFF, 3'd1, 1'b1, 1'b0, 4'h0);
        chk("bp_out1", out_data2, 8'h01);
        chk("bp_pass_rdy", in_ready2, 1);
        drive2(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 4'h0);
        chk("bp_out2", out_data2, 8'h02);
        chk("bp_out2_vld", out_valid2, 1);
        drive2(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 4'h0);
        chk("bp_out3", out_data2, 8'h03);
        chk("bp_out3_vld", out_valid2, 1);
        drive2(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 4'h0);
        chk("bp_empty", out_valid2, 0);

        // Reset with both stages full and a non-zero custom table.
        drive2(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 4'hF);
        drive2(1'b1, 8'hF0, 8'hCC, 3'd7, 1'b0, 1'b0, 4'h0);
        drive2(1'b1, 8'hF0, 8'hCC, 3'd7, 1'b0, 1'b0, 4'h0);
        drive2(1'b1, 8'hF0, 8'hCC, 3'd7, 1'b0, 1'b0, 4'h0);
        chk("mid_full", in_ready2, 0);
        chk("mid_custom_dat", out_data2, 8'hFF);
        @(negedge clk);
        rst = 1'b1; in_valid2 = 1'b1; cfg_we2 = 1'b1; cfg_table2 = 4'hF;
        #1;
        chk("mid_rst_rdy", in_ready2, 0);
        @(negedge clk);
        rst = 1'b0; in_valid2 = 1'b0; cfg_we2 = 1'b0; out_ready2 = 1'b1;
        #1;
        chk("mid_out_valid", out_valid2, 0);
        chk("mid_out_data", out_data2, 0);
        chk("mid_out_op", out_op2, 0);
        chk("mid_in_ready", in_ready2, 1);
        single("mid_cust", 3'd7, 8'hF0, 8'hCC, 8'h00);

        // Random streaming on both builds against the model.
        m_cust2 = '0; m_cust3 = '0;
        n_in2 = 0; n_out2 = 0; n_in3 = 0; n_out3 = 0;
        for (int cyc = 0; cyc < 160; cyc++) begin
            logic drain;
            drain = cyc >= 140;
            @(negedge clk);
            in_valid2  = !drain && ($urandom_range(0, 3) != 0);
            in_data2   = 16'($urandom);
            in_op2     = 3'($urandom);
            out_ready2 = drain || $urandom_range(0, 1) == 1;
            cfg_we2    = $urandom_range(0, 7) == 0;
            cfg_table2 = 4'($urandom);
            in_valid3  = !drain && ($urandom_range(0, 3) != 0);
            in_data3   = 24'($urandom);
            in_op3     = 3'($urandom);
            out_ready3 = drain || $urandom_range(0, 1) == 1;
            cfg_we3    = $urandom_range(0, 7) == 0;
            cfg_table3 = 8'($urandom);
            #1;
            if (out_valid2 && out_ready2) begin
                n_out2++;
                chk("s2_q_nonempty", q2.size() > 0, 1);
                if (q2.size() > 0) chk("s2_result", {out_op2, out_data2}, q2.pop_front());
            end
            if (in_valid2 && in_ready2) begin
                n_in2++;
                q2.push_back({in_op2, ref_eval(2, in_op2, {16'h0, in_data2}, m_cust2)});
            end
            if (cfg_we2) m_cust2 = {12'h0, cfg_table2};
            if (out_valid3 && out_ready3) begin
                n_out3++;
                chk("s3_q_nonempty", q3.size() > 0, 1);
                if (q3.size() > 0) chk("s3_result", {out_op3, out_data3}, q3.pop_front());
            end
            if (in_valid3 && in_ready3) begin
                n_in3++;
                q3.push_back({in_op3, ref_eval(3, in_op3, {8'h0, in_data3}, m_cust3)});
            end
            if (cfg_we3) m_cust3 = {8'h0, cfg_table3};
        end
        chk("s2_beats_in", n_in2 >= 16, 1);
        chk("s2_count", n_out2, n_in2);
        chk("s2_left", q2.size(), 0);
        chk("s3_beats_in", n_in3 >= 16, 1);
        chk("s3_count", n_out3, n_in3);
        chk("s3_left", q3.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
